// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz timing constants and count type for the VGA sync slice.
package vga_timing_pkg;

  localparam int CNT_W   = 11;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int HT       = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;  // 800
  localparam int VT       = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;  // 525
  localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;                          // 656
  localparam int HS_END   = HS_START + DEF_H_SYNC;                            // 752
  localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;                          // 490
  localparam int VS_END   = VS_START + DEF_V_SYNC;                            // 492

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the sync generator to the pattern stages and connector.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic pix_en;
  cnt_t hc;
  cnt_t vc;
  logic vidon;
  logic hsync;
  logic vsync;
  logic line_start;
  logic frame_start;

  modport master (
    output pix_en, hc, vc, vidon, hsync, vsync, line_start, frame_start
  );

  modport slave (
    input pix_en, hc, vc, vidon, hsync, vsync, line_start, frame_start
  );

endinterface

// File: rtl/vga_sync_gen_pix_en.sv
// Pixel-rate enable: divides the system clock by CLK_DIV into a one-clock pulse.
module vga_pix_en #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);

  localparam int DIV_W = 4;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;

  // Wrap the divider at CLK_DIV-1.
  always_comb begin
    div_next = div + 1'b1;
    if (div == DIV_LAST) div_next = '0;
  end

  // pix_en is held in a flop so reset forces it low even when CLK_DIV=1;
  // it still equals (div == CLK_DIV-1) on every cycle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      div    <= div_next;
      pix_en <= (div_next == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: hc/vc counters advanced at pixel rate, with
// vidon/hsync/vsync registered from the next-state counts so they stay
// cycle-aligned with hc/vc. hc=0,vc=0 is the first visible pixel.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  vga_sync_gen_if.master  vo
);

  localparam int LHT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int LVT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LHS_START = H_ACTIVE + H_FP;
  localparam int LHS_END   = LHS_START + H_SYNC;
  localparam int LVS_START = V_ACTIVE + V_FP;
  localparam int LVS_END   = LVS_START + V_SYNC;

  // Counts must fit the 11-bit hc/vc outputs; divider is 4 bits wide.
  if (LHT > CNT_MAX || LVT > CNT_MAX) begin : g_bad_total
    $error("vga_sync_gen: HT=%0d or VT=%0d exceeds %0d", LHT, LVT, CNT_MAX);
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV=%0d outside 1..16", CLK_DIV);
  end

  localparam cnt_t HT_LAST   = cnt_t'(LHT - 1);
  localparam cnt_t VT_LAST   = cnt_t'(LVT - 1);
  localparam cnt_t H_ACT_C   = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT_C   = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_BEG_C  = cnt_t'(LHS_START);
  localparam cnt_t HS_END_C  = cnt_t'(LHS_END);
  localparam cnt_t VS_BEG_C  = cnt_t'(LVS_START);
  localparam cnt_t VS_END_C  = cnt_t'(LVS_END);
  localparam logic SYNC_ON   = SYNC_POL;

  logic pix_en;
  cnt_t hc;
  cnt_t vc;
  cnt_t hc_next;
  cnt_t vc_next;
  logic vidon;
  logic hsync;
  logic vsync;

  vga_pix_en #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_en (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en)
  );

  // Next-state counts: advance only on a pixel-enable cycle.
  always_comb begin
    hc_next = hc;
    vc_next = vc;
    if (pix_en) begin
      if (hc == HT_LAST) begin
        hc_next = '0;
        vc_next = (vc == VT_LAST) ? '0 : vc + 1'b1;
      end else begin
        hc_next = hc + 1'b1;
      end
    end
  end

  // Counter and decode registers; decode uses next-state counts to stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc    <= HT_LAST;
      vc    <= VT_LAST;
      vidon <= 1'b0;
      hsync <= ~SYNC_ON;
      vsync <= ~SYNC_ON;
    end else begin
      hc    <= hc_next;
      vc    <= vc_next;
      vidon <= (hc_next < H_ACT_C) && (vc_next < V_ACT_C);
      hsync <= ((hc_next >= HS_BEG_C) && (hc_next < HS_END_C)) ? SYNC_ON : ~SYNC_ON;
      vsync <= ((vc_next >= VS_BEG_C) && (vc_next < VS_END_C)) ? SYNC_ON : ~SYNC_ON;
    end
  end

  assign vo.pix_en      = pix_en;
  assign vo.hc          = hc;
  assign vo.vc          = vc;
  assign vo.vidon       = vidon;
  assign vo.hsync       = hsync;
  assign vo.vsync       = vsync;
  assign vo.line_start  = pix_en && (hc == HT_LAST);
  assign vo.frame_start = pix_en && (hc == HT_LAST) && (vc == VT_LAST);

endmodule
